// File: rtl/ddr3_usr_write.sv
// Write-side EMIF user logic: streams 256-bit upstream words into single-beat Avalon-MM
// writes from a start word address for a given byte count, pulsing done at completion.
module ddr3_usr_write #(
   parameter int unsigned DATA_W = 256,
   parameter int unsigned ADDR_W = 22,
   parameter int unsigned BE_W   = 32
) (
   input  logic                ddr3_emif_clk,
   input  logic                ddr3_emif_rst_n,
   input  logic                ddr3_emif_ready,
   output logic                ddr3_emif_write,
   output logic [ADDR_W-1:0]   ddr3_emif_addr,
   output logic [DATA_W-1:0]   ddr3_emif_write_data,
   output logic [BE_W-1:0]     ddr3_emif_byte_enable,
   output logic [6:0]          ddr3_emif_burst_count,
   input  logic                ddr3_write_start,
   input  logic [26:0]         ddr3_usr_start_addr_in,
   input  logic [31:0]         to_write_byte_in,
   output logic                ddr3_write_done_out,
   input  logic [DATA_W-1:0]   write_data_in,
   input  logic                write_data_valid_in,
   output logic                write_data_ready_out,
   output logic                busy_out
);

   localparam int unsigned TAIL_W = $clog2(BE_W);
   // Word count of a full 32-bit byte count needs one bit more than 32-TAIL_W.
   localparam int unsigned CNT_W  = 33 - TAIL_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   fetch_rem;
   logic [CNT_W-1:0]   issue_rem;
   logic [TAIL_W-1:0]  tail;
   logic               first_word;
   logic [CNT_W-1:0]   words_c;
   logic [BE_W-1:0]    tail_mask_c;
   logic [BE_W-1:0]    be_nxt_c;
   logic               start_c;
   logic               accept_c;
   logic               issued_c;
   logic               unused_addr_bits;

   assign unused_addr_bits      = ^ddr3_usr_start_addr_in[26:ADDR_W];
   assign ddr3_emif_burst_count = 7'd1;

   assign start_c  = (state == IDLE) && ddr3_write_start;
   assign words_c  = CNT_W'(to_write_byte_in >> TAIL_W)
                   + CNT_W'(|to_write_byte_in[TAIL_W-1:0]);
   assign issued_c = ddr3_emif_write && ddr3_emif_ready;

   // Combinational from ddr3_emif_ready so a word can be taken every cycle.
   assign write_data_ready_out = (state == WRITE) && (fetch_rem != '0)
                               && (!ddr3_emif_write || ddr3_emif_ready);
   assign accept_c = write_data_valid_in && write_data_ready_out;

   // Partial byte enables only on the final word of a non-multiple byte count.
   always_comb begin
      tail_mask_c = '0;
      for (int unsigned i = 0; i < BE_W; i++) begin
         tail_mask_c[i] = (TAIL_W'(i) < tail);
      end
      be_nxt_c = '1;
      if ((fetch_rem == CNT_W'(1)) && (tail != '0)) begin
         be_nxt_c = tail_mask_c;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (ddr3_write_start) begin
               state_nxt = (to_write_byte_in == 32'd0) ? DONE : WRITE;
            end
         end
         WRITE: begin
            if (issued_c && (issue_rem == CNT_W'(1))) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ddr3_emif_clk or negedge ddr3_emif_rst_n) begin
      if (!ddr3_emif_rst_n) begin
         state               <= IDLE;
         fetch_rem           <= '0;
         issue_rem           <= '0;
         tail                <= '0;
         first_word          <= 1'b0;
         ddr3_write_done_out <= 1'b0;
         busy_out            <= 1'b0;
      end else begin
         state               <= state_nxt;
         ddr3_write_done_out <= (state == DONE);
         busy_out            <= (state_nxt != IDLE) || (state == DONE);
         if (start_c) begin
            fetch_rem  <= words_c;
            issue_rem  <= words_c;
            tail       <= to_write_byte_in[TAIL_W-1:0];
            first_word <= 1'b1;
         end else begin
            if (accept_c) begin
               fetch_rem  <= fetch_rem - CNT_W'(1);
               first_word <= 1'b0;
            end
            if (issued_c) begin
               issue_rem <= issue_rem - CNT_W'(1);
            end
         end
      end
   end

   // Avalon output register: holds while write is pending and not yet accepted.
   always_ff @(posedge ddr3_emif_clk or negedge ddr3_emif_rst_n) begin
      if (!ddr3_emif_rst_n) begin
         ddr3_emif_write       <= 1'b0;
         ddr3_emif_addr        <= '0;
         ddr3_emif_write_data  <= '0;
         ddr3_emif_byte_enable <= '0;
      end else begin
         if (start_c) begin
            ddr3_emif_addr <= ddr3_usr_start_addr_in[ADDR_W-1:0];
         end
         if (accept_c) begin
            ddr3_emif_write       <= 1'b1;
            ddr3_emif_write_data  <= write_data_in;
            ddr3_emif_byte_enable <= be_nxt_c;
            if (!first_word) begin
               ddr3_emif_addr <= ddr3_emif_addr + ADDR_W'(1);
            end
         end else if (issued_c) begin
            ddr3_emif_write <= 1'b0;
         end
      end
   end

endmodule
